prog_loader: RTL and testbench
==============================

Name: prog_loader

Overview:
- Byte-stream program loader that sits upstream of the accumulator processor's Memory.
- Receives a length-prefixed byte stream over a valid/ready handshake and assembles 18-bit words.
- Writes the words to consecutive memory addresses starting at BASE_ADDR.
- Holds the processor in reset (cpu_hold) while a load is in progress, then releases it.

Parameters:
- DATA_W, 18, memory word width; fixed 3-byte packing assumes DATA_W <= 24.
- ADDR_W, 13, memory address width.
- BASE_ADDR, 0, first memory address written.

Ports:
- clk  input  1  system clock; the same clock as the processor's memory.
- reset  input  1  synchronous, active-high reset.
- start  input  1  single-cycle request to begin a load.
- rx_data  input  8  incoming stream byte.
- rx_valid  input  1  rx_data is valid this cycle.
- rx_ready  output  1  loader accepts a byte this cycle.
- mem_addr  output  ADDR_W  write address to Memory.
- mem_data  output  DATA_W  write data to Memory.
- mem_wr  output  1  one-cycle memory write strobe.
- cpu_hold  output  1  held high while loading; ORed into the processor reset by the top level.
- busy  output  1  load in progress.
- done  output  1  last load completed successfully; sticky.
- err  output  1  last load aborted; sticky.

Behaviour:
- Clock and reset:
  - One clock domain; all registers update on the rising edge of clk.
  - reset is synchronous and active-high.
  - Reset has priority over every other input, including mid-load. It forces the state to IDLE, outputs the reset values below, and discards the partial word, count and checksum.
- Reset values: rx_ready=0, mem_wr=0, mem_addr=BASE_ADDR, mem_data=0, cpu_hold=0, busy=0, done=0, err=0.
- Handshake: a byte is accepted only when rx_valid and rx_ready are both 1 in the same cycle. rx_data is ignored otherwise.
- Stream format, big-endian:
  - LEN_HI, LEN_LO: 16-bit word count N.
  - Then N groups of 3 bytes per word. Byte 0 bits [1:0] form word[17:16]; byte 0 bits [7:2] are ignored. Byte 1 forms word[15:8]. Byte 2 forms word[7:0].
- States: IDLE, LEN_HI, LEN_LO, B0, B1, B2, WRITE, CHK (only with the optional feature), DONE, ERR.
- IDLE / DONE / ERR:
  - rx_ready=0.
  - start=1 moves to LEN_HI, clears done and err, sets cpu_hold=1 and busy=1, and loads mem_addr=BASE_ADDR.
- LEN_HI, LEN_LO: rx_ready=1; each accepted byte advances one state.
- After LEN_LO is accepted:
  - If N > 2^ADDR_W - BASE_ADDR, go to ERR.
  - Else if N == 0, go to the end state (CHK if enabled, otherwise DONE).
  - Else go to B0.
- B0, B1, B2: rx_ready=1; the accepted byte is latched into the word register. Acceptance in B2 goes to WRITE.
- WRITE:
  - rx_ready=0; mem_wr=1 for exactly one cycle with mem_addr/mem_data stable.
  - Next cycle: mem_addr increments and the remaining count decrements.
  - If the remaining count reaches 0, go to the end state; otherwise go to B0.
  - Latency: the write strobe occurs 1 cycle after the B2 byte is accepted.
- DONE: done=1, busy=0, cpu_hold=0.
- ERR: err=1, busy=0, cpu_hold stays 1 until the next start or reset, so the processor never runs a partial image.
- start asserted while busy is ignored.
- rx_valid in IDLE/DONE/ERR is not accepted; bytes are not consumed.
- mem_addr never wraps: the range check guarantees the last write is at 2^ADDR_W-1 or below.

Optional Feature:
- Macro: PROG_LOADER_CHECKSUM_EN.
- Defined:
  - After the last word (or after LEN_LO when N=0), state CHK accepts one byte with rx_ready=1.
  - Running checksum is the XOR of every accepted byte from LEN_HI through the last data byte, cleared on start.
  - Received byte equal to the checksum: go to DONE. Unequal: go to ERR.
  - Memory writes already issued are not undone.
- Undefined: no CHK state or checksum register; the end state is DONE.

Test Plan:
- Two-word load: start, then bytes 00 02 03 FF FE 01 23 45 -> mem_wr at addr 0 data 0x3FFFE, then addr 1 data 0x12345. done=1, cpu_hold falls after the last write, err=0. With checksum enabled, append byte 0x67 -> done=1.
- Zero length: start, then bytes 00 00 -> no mem_wr, done=1. With checksum enabled, byte 0x00 is also required.
- Overlength: BASE_ADDR=0, bytes 20 01 (N=8193) -> ERR, err=1, cpu_hold stays 1, no mem_wr.
- Handshake gaps: rx_valid toggled randomly during the two-word load -> identical writes. No byte is consumed during WRITE (rx_ready=0).
- Start while busy, then reset mid-load:
  - Assert start after LEN_LO -> ignored.
  - Assert reset after B1 -> next cycle all outputs at reset values, no mem_wr.
  - A fresh load then succeeds.
- Checksum mismatch (feature enabled): two-word stream with checksum 0x66 -> err=1, cpu_hold=1, both words were still written.

Source files
------------

// File: rtl/prog_loader.sv
// Byte-stream program loader: length-prefixed stream -> 18-bit memory words.
// Optional trailing XOR checksum byte when PROG_LOADER_CHECKSUM_EN is defined.
module prog_loader #(
    parameter int unsigned DATA_W    = 18,
    parameter int unsigned ADDR_W    = 13,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_wr,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [3:0] {
        IDLE,
        LEN_HI,
        LEN_LO,
        B0,
        B1,
        B2,
        WRITE,
`ifdef PROG_LOADER_CHECKSUM_EN
        CHK,
`endif
        DONE,
        ERR
    } state_t;

`ifdef PROG_LOADER_CHECKSUM_EN
    localparam state_t END_STATE = CHK;
`else
    localparam state_t END_STATE = DONE;
`endif

    // Largest word count that still fits between BASE_ADDR and the top of memory.
    localparam logic [31:0] MAX_WORDS = (32'd1 << ADDR_W) - 32'(BASE_ADDR);

    state_t            state;
    state_t            nextState;
    logic [15:0]       wordCount;
    logic [DATA_W-1:0] wordBuf;
    logic [15:0]       lenWord;
    logic              accept;
    logic              idleLike;
    logic              tooLong;

`ifdef PROG_LOADER_CHECKSUM_EN
    logic [7:0]        checksum;
`endif

    assign accept   = rx_valid & rx_ready;
    assign idleLike = (state == IDLE) | (state == DONE) | (state == ERR);
    assign lenWord  = {wordCount[15:8], rx_data};
    assign tooLong  = {16'd0, lenWord} > MAX_WORDS;
    assign mem_data = wordBuf;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        unique case (state)
            IDLE, DONE, ERR: begin
                if (start) nextState = LEN_HI;
            end
            LEN_HI: begin
                if (accept) nextState = LEN_LO;
            end
            LEN_LO: begin
                if (accept) begin
                    if (tooLong) begin
                        nextState = ERR;
                    end else if (lenWord == 16'd0) begin
                        nextState = END_STATE;
                    end else begin
                        nextState = B0;
                    end
                end
            end
            B0: begin
                if (accept) nextState = B1;
            end
            B1: begin
                if (accept) nextState = B2;
            end
            B2: begin
                if (accept) nextState = WRITE;
            end
            WRITE: begin
                nextState = (wordCount == 16'd1) ? END_STATE : B0;
            end
`ifdef PROG_LOADER_CHECKSUM_EN
            CHK: begin
                if (accept) nextState = (rx_data == checksum) ? DONE : ERR;
            end
`endif
            default: nextState = IDLE;
        endcase
    end

    always_comb begin
        rx_ready = 1'b0;
        mem_wr   = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        err      = 1'b0;
        unique case (state)
            LEN_HI, LEN_LO, B0, B1, B2: begin
                rx_ready = 1'b1;
                busy     = 1'b1;
            end
`ifdef PROG_LOADER_CHECKSUM_EN
            CHK: begin
                rx_ready = 1'b1;
                busy     = 1'b1;
            end
`endif
            WRITE: begin
                mem_wr = 1'b1;
                busy   = 1'b1;
            end
            DONE:    done = 1'b1;
            ERR:     err  = 1'b1;
            default: ;
        endcase
        // An aborted image keeps the processor parked until the next start.
        cpu_hold = busy | err;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_addr  <= ADDR_W'(BASE_ADDR);
            wordBuf   <= '0;
            wordCount <= '0;
        end else begin
            if (start && idleLike) begin
                mem_addr <= ADDR_W'(BASE_ADDR);
            end
            if (accept) begin
                unique case (state)
                    LEN_HI:  wordCount[15:8]    <= rx_data;
                    LEN_LO:  wordCount[7:0]     <= rx_data;
                    B0:      wordBuf[DATA_W-1:16] <= rx_data[DATA_W-17:0];
                    B1:      wordBuf[15:8]      <= rx_data;
                    B2:      wordBuf[7:0]       <= rx_data;
                    default: ;
                endcase
            end
            if (state == WRITE) begin
                wordCount <= wordCount - 16'd1;
                // Saturate so a write at the top address never wraps to zero.
                if (mem_addr != '1) begin
                    mem_addr <= mem_addr + ADDR_W'(1);
                end
            end
        end
    end

`ifdef PROG_LOADER_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            checksum <= '0;
        end else if (start && idleLike) begin
            checksum <= '0;
        end else if (accept && state != CHK) begin
            checksum <= checksum ^ rx_data;
        end
    end
`endif

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: scoreboard of expected memory writes
// plus directed status checks; follows PROG_LOADER_CHECKSUM_EN if defined.
module tb_prog_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [12:0] mem_addr;
    logic [17:0] mem_data;
    logic        mem_wr;
    logic        cpu_hold;
    logic        busy;
    logic        done;
    logic        err;

    int tests = 0;
    int fails = 0;
    int nWrites = 0;

    logic [30:0] expQ[$];

    prog_loader dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .rx_ready(rx_ready),
        .mem_addr(mem_addr),
        .mem_data(mem_data),
        .mem_wr(mem_wr),
        .cpu_hold(cpu_hold),
        .busy(busy),
        .done(done),
        .err(err)
    );

    always #5 clk = ~clk;

    // Write monitor: every strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (mem_wr) begin
            logic [30:0] e;
            nWrites++;
            tests++;
            if (expQ.size() == 0) begin
                fails++;
                $display("FAIL memWrite: unexpected write addr %0h data %0h, none required",
                         mem_addr, mem_data);
            end else begin
                e = expQ.pop_front();
                if ({mem_addr, mem_data} !== e) begin
                    fails++;
                    $display("FAIL memWrite: got addr %0h data %0h, required addr %0h data %0h",
                             mem_addr, mem_data, e[30:18], e[17:0]);
                end
            end
            tests++;
            if (rx_ready !== 1'b0) begin
                fails++;
                $display("FAIL readyInWrite: got rx_ready %b, required 0", rx_ready);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic sendByte(input logic [7:0] b, input bit gaps);
        bit ok;
        if (gaps) begin
            rx_valid = 1'b0;
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk);
                #1;
            end
        end
        rx_data  = b;
        rx_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (rx_ready) ok = 1'b1;
            @(posedge clk);
            #1;
        end
        rx_valid = 1'b0;
        if (!ok) begin
            tests++;
            fails++;
            $display("FAIL byteTimeout: byte %0h not accepted, required accept", b);
        end
    endtask

    task automatic sendWord(input logic [7:0] b0, b1, b2, input bit gaps);
        sendByte(b0, gaps);
        sendByte(b1, gaps);
        sendByte(b2, gaps);
        check("writeLatency", {31'd0, mem_wr}, 32'd1);
    endtask

    task automatic pulseStart();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic waitEnd();
        bit ended;
        ended = 1'b0;
        for (int i = 0; i < 200 && !ended; i++) begin
            @(negedge clk);
            if (!busy) ended = 1'b1;
        end
        if (!ended) begin
            tests++;
            fails++;
            $display("FAIL endTimeout: busy still 1, required 0");
        end
    endtask

    task automatic checkStatus(input string tag, input logic d, e, h);
        check({tag, ".done"}, {31'd0, done}, {31'd0, d});
        check({tag, ".err"}, {31'd0, err}, {31'd0, e});
        check({tag, ".cpuHold"}, {31'd0, cpu_hold}, {31'd0, h});
        check({tag, ".busy"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic checkResetVals(input string tag);
        check({tag, ".rxReady"}, {31'd0, rx_ready}, 32'd0);
        check({tag, ".memWr"}, {31'd0, mem_wr}, 32'd0);
        check({tag, ".memAddr"}, {19'd0, mem_addr}, 32'd0);
        check({tag, ".memData"}, {14'd0, mem_data}, 32'd0);
        check({tag, ".cpuHold"}, {31'd0, cpu_hold}, 32'd0);
        check({tag, ".busy"}, {31'd0, busy}, 32'd0);
        check({tag, ".done"}, {31'd0, done}, 32'd0);
        check({tag, ".err"}, {31'd0, err}, 32'd0);
    endtask

    // Two-word image: 0x3FFFE at 0, 0x12345 at 1; XOR of all bytes is 0x67.
    task automatic twoWordLoad(input bit gaps, input logic [7:0] sum, input bit midStart);
        int w0;
        w0 = nWrites;
        expQ.push_back({13'd0, 18'h3FFFE});
        expQ.push_back({13'd1, 18'h12345});
        pulseStart();
        check("startBusy", {31'd0, busy}, 32'd1);
        sendByte(8'h00, gaps);
        sendByte(8'h02, gaps);
        if (midStart) pulseStart();
        sendWord(8'h03, 8'hFF, 8'hFE, gaps);
        sendWord(8'h01, 8'h23, 8'h45, gaps);
`ifdef PROG_LOADER_CHECKSUM_EN
        sendByte(sum, gaps);
`endif
        waitEnd();
        check("twoWordCount", nWrites - w0, 32'd2);
    endtask

    initial begin
        int w0;
        reset    = 1'b1;
        start    = 1'b0;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        checkResetVals("reset");

        // Bytes offered while idle must not be taken.
        rx_valid = 1'b1;
        rx_data  = 8'hA5;
        @(negedge clk);
        check("idleReady", {31'd0, rx_ready}, 32'd0);
        @(posedge clk);
        #1;
        rx_valid = 1'b0;

        twoWordLoad(1'b0, 8'h67, 1'b0);
        checkStatus("twoWord", 1'b1, 1'b0, 1'b0);

        w0 = nWrites;
        pulseStart();
        sendByte(8'h00, 1'b0);
        sendByte(8'h00, 1'b0);
`ifdef PROG_LOADER_CHECKSUM_EN
        sendByte(8'h00, 1'b0);
`endif
        waitEnd();
        check("zeroLenWrites", nWrites - w0, 32'd0);
        checkStatus("zeroLen", 1'b1, 1'b0, 1'b0);

        w0 = nWrites;
        pulseStart();
        sendByte(8'h20, 1'b0);
        sendByte(8'h01, 1'b0);
        waitEnd();
        check("overLenWrites", nWrites - w0, 32'd0);
        checkStatus("overLen", 1'b0, 1'b1, 1'b1);
        check("errReady", {31'd0, rx_ready}, 32'd0);

        twoWordLoad(1'b1, 8'h67, 1'b0);
        checkStatus("gaps", 1'b1, 1'b0, 1'b0);

        // Abort after B1 with a reset; the partial word must not be written.
        w0 = nWrites;
        pulseStart();
        sendByte(8'h00, 1'b0);
        sendByte(8'h02, 1'b0);
        sendByte(8'h03, 1'b0);
        sendByte(8'hFF, 1'b0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        checkResetVals("midReset");
        repeat (3) @(negedge clk);
        check("midResetWrites", nWrites - w0, 32'd0);

        @(posedge clk);
        #1;
        twoWordLoad(1'b0, 8'h67, 1'b1);
        checkStatus("afterReset", 1'b1, 1'b0, 1'b0);

`ifdef PROG_LOADER_CHECKSUM_EN
        twoWordLoad(1'b0, 8'h66, 1'b0);
        checkStatus("badSum", 1'b0, 1'b1, 1'b1);
`endif

        repeat (2) @(negedge clk);
        check("queueEmpty", expQ.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
